mod_seq_checker: RTL and testbench



---
 rtl/mod_seq_checker.sv | 117 +++++++++++
 tb/tb_mod_seq_checker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_seq_checker.sv
// Downstream checker for a modulo-MOD counter: locks onto the 0..MOD-1 sequence,
// flags illegal steps with a sticky error, and counts/pulses wraps while locked.
module mod_seq_checker #(
  parameter int unsigned MOD      = 5,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned LOCK_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              clr_err,
  output logic              locked,
  output logic              err,
  output logic [CNT_W-1:0]  err_value,
  output logic [CNT_W-1:0]  err_expected,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam int unsigned MC_W = $clog2(LOCK_LEN + 1);

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED, ERROR} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  prev, prev_next;
  logic [CNT_W-1:0]  exp_val;
  logic [CNT_W-1:0]  err_value_next, err_expected_next;
  logic [MC_W-1:0]   match_cnt, match_cnt_next;
  logic [WRAP_W-1:0] wrap_count_next;
  logic              wrap_pulse_next;
  logic              step_ok;

  // Expected next counter value; out-of-range inputs can never equal it
  always_comb begin
    exp_val = (prev == CNT_W'(MOD - 1)) ? '0 : prev + CNT_W'(1);
    step_ok = (cnt_in == exp_val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prev         <= '0;
      match_cnt    <= '0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_value    <= '0;
      err_expected <= '0;
      wrap_pulse   <= 1'b0;
      wrap_count   <= '0;
    end else begin
      state        <= state_next;
      prev         <= prev_next;
      match_cnt    <= match_cnt_next;
      locked       <= (state_next == LOCKED);
      err          <= (state_next == ERROR);
      err_value    <= err_value_next;
      err_expected <= err_expected_next;
      wrap_pulse   <= wrap_pulse_next;
      wrap_count   <= wrap_count_next;
    end
  end

  always_comb begin
    state_next        = state;
    prev_next         = prev;
    match_cnt_next    = match_cnt;
    err_value_next    = err_value;
    err_expected_next = err_expected;
    wrap_pulse_next   = 1'b0;
    wrap_count_next   = wrap_count;

    case (state)
      IDLE: begin
        if (cnt_in == '0) begin
          prev_next      = '0;
          match_cnt_next = '0;
          state_next     = SYNC;
        end
      end
      SYNC: begin
        if (step_ok) begin
          prev_next      = cnt_in;
          match_cnt_next = match_cnt + MC_W'(1);
          if (match_cnt == MC_W'(LOCK_LEN - 1)) state_next = LOCKED;
        end else begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        if (step_ok) begin
          prev_next = cnt_in;
          if (prev == CNT_W'(MOD - 1)) begin
            wrap_pulse_next = 1'b1;
            if (wrap_count != '1) wrap_count_next = wrap_count + WRAP_W'(1);
          end
        end else begin
          state_next        = ERROR;
          err_value_next    = cnt_in;
          err_expected_next = exp_val;
        end
      end
      ERROR: begin
        if (clr_err) begin
          state_next        = IDLE;
          err_value_next    = '0;
          err_expected_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Clear has priority over a same-edge wrap increment; the pulse still fires
    if (clr_err) wrap_count_next = '0;
  end

endmodule

// File: tb/tb_mod_seq_checker.sv
// Bench for mod_seq_checker: directed scenarios plus a randomized run against a
// rule-level reference model; a second instance uses a 2-bit wrap counter.
module tb_mod_seq_checker;

  localparam int MOD = 5;
  localparam int LOCK_LEN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] cnt_in = 3'd0;
  logic       clr_err = 1'b0;

  logic       locked, err, wrap_pulse;
  logic [2:0] err_value, err_expected;
  logic [7:0] wrap_count;
  logic       locked2, err2, wrap_pulse2;
  logic [2:0] err_value2, err_expected2;
  logic [1:0] wrap_count2;

  int checks = 0;
  int errors = 0;

  // Reference model: "phase" 0=waiting for 0, 1=syncing, 2=locked, 3=error
  int m_phase, m_last, m_run, m_wc, m_wc2, m_ev, m_ee;
  bit m_pulse;

  always #5 clk = ~clk;

  mod_seq_checker dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr_err(clr_err),
    .locked(locked), .err(err), .err_value(err_value), .err_expected(err_expected),
    .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
  );

  mod_seq_checker #(.WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr_err(clr_err),
    .locked(locked2), .err(err2), .err_value(err_value2), .err_expected(err_expected2),
    .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2)
  );

  task automatic model_reset();
    m_phase = 0; m_last = 0; m_run = 0; m_wc = 0; m_wc2 = 0;
    m_ev = 0; m_ee = 0; m_pulse = 0;
  endtask

  task automatic model_update(input int v, input bit cl);
    int want;
    want = (m_last + 1) % MOD;
    m_pulse = 0;
    if (m_phase == 0) begin
      if (v == 0) begin m_last = 0; m_run = 0; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (v == want) begin
        m_last = v; m_run = m_run + 1;
        if (m_run >= LOCK_LEN) m_phase = 2;
      end else m_phase = 0;
    end else if (m_phase == 2) begin
      if (v == want) begin
        if (v == 0) begin
          m_pulse = 1;
          m_wc  = (m_wc  < 255) ? m_wc + 1  : 255;
          m_wc2 = (m_wc2 < 3)   ? m_wc2 + 1 : 3;
        end
        m_last = v;
      end else begin
        m_phase = 3; m_ev = v; m_ee = want;
      end
    end else if (cl) begin
      m_phase = 0; m_ev = 0; m_ee = 0;
    end
    if (cl) begin m_wc = 0; m_wc2 = 0; end
  endtask

  // Drive one sample at the falling edge, let it be taken on the rising edge
  task automatic tick(input int v, input bit cl = 1'b0);
    cnt_in = 3'(v);
    clr_err = cl;
    @(posedge clk);
    model_update(v, cl);
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({locked, err, err_value, err_expected, wrap_pulse, wrap_count} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {locked, err, err_value, err_expected, wrap_pulse, wrap_count});
    end
    do_reset();
  endtask

  task automatic test_lock_wrap();
    tick(0); tick(1); tick(2);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", locked); end
    tick(3);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL lock_on_3 got %b want 1", locked); end
    tick(4);
    for (int r = 0; r < 4; r++) begin
      tick(0);
      checks++;
      if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL wrap_pulse_%0d got %b want 1", r, wrap_pulse); end
      tick(1);
      checks++;
      if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL wrap_pulse_off_%0d got %b want 0", r, wrap_pulse); end
      tick(2); tick(3); tick(4);
    end
    checks++;
    if (wrap_count !== 8'd4) begin errors++; $display("FAIL wrap_count4 got %0d want 4", wrap_count); end
    checks++;
    if (wrap_count2 !== 2'd3) begin errors++; $display("FAIL wrap_sat got %0d want 3", wrap_count2); end
  endtask

  task automatic test_skip();
    tick(0); tick(1); tick(2); tick(4);
    checks++;
    if ({err, locked, err_value, err_expected, wrap_count} !== {1'b1, 1'b0, 3'd4, 3'd3, 8'd5}) begin
      errors++;
      $display("FAIL skip_err got err=%b locked=%b val=%0d exp=%0d wc=%0d want 1 0 4 3 5",
               err, locked, err_value, err_expected, wrap_count);
    end
    tick(0); tick(1); tick(2); tick(3); tick(4); tick(0);
    checks++;
    if ({err, err_value, err_expected, wrap_count, wrap_pulse} !== {1'b1, 3'd4, 3'd3, 8'd5, 1'b0}) begin
      errors++;
      $display("FAIL err_hold got err=%b val=%0d exp=%0d wc=%0d pulse=%b want 1 4 3 5 0",
               err, err_value, err_expected, wrap_count, wrap_pulse);
    end
  endtask

  task automatic test_stall_clear();
    tick(0, 1'b1);
    checks++;
    if ({err, err_value, err_expected, wrap_count, locked} !== 15'd0) begin
      errors++;
      $display("FAIL clr_err got err=%b val=%0d exp=%0d wc=%0d locked=%b want all 0",
               err, err_value, err_expected, wrap_count, locked);
    end
    tick(0); tick(1); tick(2); tick(3);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock_after_clr got %b want 1", locked); end
    tick(3);
    checks++;
    if ({err, err_value, err_expected} !== {1'b1, 3'd3, 3'd4}) begin
      errors++;
      $display("FAIL stall_err got err=%b val=%0d exp=%0d want 1 3 4", err, err_value, err_expected);
    end
    tick(2, 1'b1);
  endtask

  task automatic test_range_sync();
    tick(0); tick(1); tick(2); tick(3); tick(6);
    checks++;
    if ({err, err_value, err_expected} !== {1'b1, 3'd6, 3'd4}) begin
      errors++;
      $display("FAIL range_err got err=%b val=%0d exp=%0d want 1 6 4", err, err_value, err_expected);
    end
    tick(1, 1'b1);
    tick(0); tick(1); tick(5);
    checks++;
    if ({err, locked} !== 2'b00) begin errors++; $display("FAIL sync_no_err got %b want 00", {err, locked}); end
    tick(1); tick(0); tick(1); tick(2);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL sync_not_yet got %b want 0", locked); end
    tick(3);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock_after_sync got %b want 1", locked); end
  endtask

  task automatic test_clr_on_wrap();
    tick(4); tick(0); tick(1); tick(2); tick(3); tick(4);
    tick(0, 1'b1);
    checks++;
    if ({wrap_pulse, wrap_count, wrap_pulse2, wrap_count2} !== {1'b1, 8'd0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL clr_on_wrap got pulse=%b wc=%0d pulse2=%b wc2=%0d want 1 0 1 0",
               wrap_pulse, wrap_count, wrap_pulse2, wrap_count2);
    end
    tick(1);
    checks++;
    if ({wrap_pulse, locked} !== 2'b01) begin
      errors++;
      $display("FAIL after_clr_wrap got pulse=%b locked=%b want 0 1", wrap_pulse, locked);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(0); tick(1);
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick(2); tick(3); tick(4);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL rst_mid_sync got locked=%b want 0", locked); end
    tick(0); tick(1); tick(2); tick(3); tick(4); tick(0); tick(1); tick(7);
    checks++;
    if ({err, err_value, err_expected, wrap_count} !== {1'b1, 3'd7, 3'd2, 8'd1}) begin
      errors++;
      $display("FAIL pre_rst_err got err=%b val=%0d exp=%0d wc=%0d want 1 7 2 1",
               err, err_value, err_expected, wrap_count);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({locked, err, err_value, err_expected, wrap_pulse, wrap_count} !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_err got %h want 0",
               {locked, err, err_value, err_expected, wrap_pulse, wrap_count});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int c, v, r;
    bit cl;
    c = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(99));
      if (r < 85)      c = (c + 1) % MOD;
      else if (r < 90) c = (c + 2) % MOD;
      else if (r < 95) c = c;
      else             c = int'($urandom_range(7));
      v = c;
      if (c >= MOD) c = 0;
      cl = ($urandom_range(99) < 4);
      tick(v, cl);
      checks++;
      if ({locked, err, wrap_pulse} !== {m_phase == 2, m_phase == 3, m_pulse}) begin
        errors++;
        $display("FAIL rnd_flags cyc %0d got %b%b%b want %b%b%b", i, locked, err, wrap_pulse,
                 m_phase == 2, m_phase == 3, m_pulse);
      end
      checks++;
      if ({err_value, err_expected} !== {3'(m_ev), 3'(m_ee)}) begin
        errors++;
        $display("FAIL rnd_errinfo cyc %0d got %0d/%0d want %0d/%0d", i, err_value, err_expected, m_ev, m_ee);
      end
      checks++;
      if ({wrap_count, wrap_count2, wrap_pulse2} !== {8'(m_wc), 2'(m_wc2), m_pulse}) begin
        errors++;
        $display("FAIL rnd_wrap cyc %0d got %0d/%0d/%b want %0d/%0d/%b", i, wrap_count,
                 wrap_count2, wrap_pulse2, m_wc, m_wc2, m_pulse);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_wrap();
    test_skip();
    test_stall_clear();
    test_range_sync();
    test_clr_on_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
